// File: rtl/idivu.sv
// rtl/idivu.sv - iterative unsigned divider, 2W/W -> W quotient and remainder, one bit per clock
// Optional macro IDIVU_FAST_OVF_EN: overflowing divisions finish after a single busy cycle.
module idivu #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               arstn,
  input  logic               go,
  input  logic [2*WIDTH-1:0] a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic [WIDTH-1:0]   q,
  output logic [WIDTH-1:0]   r,
  output logic               ovf
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [4:0] LAST = 5'(WIDTH - 1);

  state_t             state;
  logic [4:0]         count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   d;

  logic [WIDTH:0]     part;
  logic [WIDTH-1:0]   diff;
  logic               fits;
  logic               ovf_in;

  // Only the low WIDTH bits of the difference survive; the top bit of part
  // still takes part in the compare, which is what decides the quotient bit.
  assign part   = acc[2*WIDTH-1:WIDTH-1];
  assign diff   = part[WIDTH-1:0] - d;
  assign fits   = (part >= {1'b0, d});
  assign ovf_in = (a[2*WIDTH-1:WIDTH] >= b);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state <= IDLE;
      busy  <= 1'b0;
      count <= '0;
      acc   <= '0;
      d     <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            state <= RUN;
            busy  <= 1'b1;
            acc   <= a;
            d     <= b;
            ovf   <= ovf_in;
`ifdef IDIVU_FAST_OVF_EN
            count <= ovf_in ? 5'd0 : LAST;
`else
            count <= LAST;
`endif
          end
        end
        RUN: begin
          if (fits)
            acc <= {diff, acc[WIDTH-2:0], 1'b1};
          else
            acc <= {acc[2*WIDTH-2:0], 1'b0};
          if (count != 5'd0) begin
            count <= count - 5'd1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign q = ovf ? '1 : acc[WIDTH-1:0];
  assign r = ovf ? '1 : acc[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_idivu.sv
// tb/tb_idivu.sv - scoreboard bench for idivu, WIDTH=8
module tb_idivu;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic        go = 1'b0;
  logic [15:0] a = '0;
  logic [7:0]  b = '0;
  logic        busy;
  logic [7:0]  q;
  logic [7:0]  r;
  logic        ovf;

  idivu #(.WIDTH(8)) dut (
    .clk  (clk),
    .arstn(arstn),
    .go   (go),
    .a    (a),
    .b    (b),
    .busy (busy),
    .q    (q),
    .r    (r),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

`ifdef IDIVU_FAST_OVF_EN
  localparam int OVF_LAT = 1;
`else
  localparam int OVF_LAT = 8;
`endif

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        ovf;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] aa, input logic [7:0] bb,
                              input logic [7:0] qq, input logic [7:0] rr, input logic ov);
    exp_t e;
    e.a = aa; e.b = bb; e.q = qq; e.r = rr; e.ovf = ov;
    e.lat = ov ? OVF_LAT : 8;
    return e;
  endfunction

  // Reference model for the random sweep: plain integer division.
  function automatic exp_t model(input logic [15:0] aa, input logic [7:0] bb);
    if (aa[15:8] >= bb) return mk(aa, bb, 8'hFF, 8'hFF, 1'b1);
    return mk(aa, bb, 8'(aa / {8'h00, bb}), 8'(aa % {8'h00, bb}), 1'b0);
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("wait_idle_timeout", 32'(n), 32'd0);
  endtask

  task automatic issue(input exp_t e);
    wait_idle();
    go = 1'b1;
    a  = e.a;
    b  = e.b;
    sb.push_back(e);
    @(negedge clk);
    go = 1'b0;
  endtask

  // Monitor: a falling busy marks a completed division.
  int  busy_cnt = 0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (!arstn) begin
      sb.delete();
      busy_cnt  = 0;
      prev_busy = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (prev_busy && !busy) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("q", 32'(q), 32'(e.q));
          chk("r", 32'(r), 32'(e.r));
          chk("ovf", 32'(ovf), 32'(e.ovf));
          chk("busy_cycles", 32'(busy_cnt), 32'(e.lat));
          if (!e.ovf) begin
            chk("identity", 32'(q) * 32'(e.b) + 32'(r), 32'(e.a));
            chk("r_lt_b", 32'(r < e.b), 32'd1);
          end
        end
        busy_cnt = 0;
      end
      prev_busy = busy;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_r", 32'(r), 32'd0);
    @(negedge clk);
    @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);

    issue(mk(16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0));
    issue(mk(16'h1234, 8'h56, 8'h36, 8'h10, 1'b0));
    issue(mk(16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0));
    issue(mk(16'h0700, 8'h07, 8'hFF, 8'hFF, 1'b1));
    issue(mk(16'h0010, 8'h00, 8'hFF, 8'hFF, 1'b1));
    issue(mk(16'h0006, 8'h07, 8'h00, 8'h06, 1'b0));

    // go during busy must be ignored
    issue(mk(16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0));
    @(negedge clk);
    @(negedge clk);
    go = 1'b1; a = 16'h0005; b = 8'h01;
    @(negedge clk);
    go = 1'b0;

    // asynchronous reset at busy cycle 4
    issue(mk(16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0));
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1 arstn = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    chk("abort_q", 32'(q), 32'd0);
    chk("abort_r", 32'(r), 32'd0);
    @(negedge clk);
    @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);
    issue(mk(16'h1234, 8'h56, 8'h36, 8'h10, 1'b0));

    // back-to-back: go held across completion
    issue(mk(16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0));
    go = 1'b1; a = 16'h1234; b = 8'h56;
    sb.push_back(mk(16'h1234, 8'h56, 8'h36, 8'h10, 1'b0));
    wait_idle();
    @(negedge clk);
    chk("b2b_restart", 32'(busy), 32'd1);
    go = 1'b0;

    for (int i = 0; i < 24; i++) begin
      logic [15:0] ra;
      logic [7:0]  rb;
      ra = 16'($urandom);
      rb = 8'($urandom);
      if (i % 3 != 0) ra[15:8] = 8'(ra[15:8] % (rb == 8'h00 ? 8'h01 : rb));
      issue(model(ra, rb));
    end

    wait_idle();
    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
